// File: rtl/m1_core_pkg.sv
// Shared types and constants for the M1 writeback path.
package m1_core_pkg;

  localparam int DATA_W        = 16;
  localparam int ADDR_W        = 4;
  localparam int M1_FIFO_DEPTH = 4;

  // One register-file write: destination register plus result data.
  typedef struct packed {
    logic [ADDR_W-1:0] dest;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  // Which source owns the write port this cycle.
  typedef enum logic [1:0] {
    WB_NONE       = 2'd0,
    WB_ALU        = 2'd1,
    WB_MUL_FIFO   = 2'd2,
    WB_MUL_BYPASS = 2'd3
  } wb_src_e;

endpackage

// File: rtl/wb_arbiter_m1_chk.sv
// Simulation-only protocol checks for the writeback arbiter.
module wb_arbiter_m1_chk #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 3
) (
  input logic             clk,
  input logic             async_rst_n,
  input logic             clk_en,
  input logic             mul_call,
  input logic [CNT_W-1:0] credits,
  input logic [CNT_W-1:0] fifo_count,
  input logic             fifo_push,
  input logic             fifo_pop,
  input logic             fifo_full
);

  // The issue stage must never call the multiplier without a credit.
  a_call_without_credit: assert property (@(posedge clk) disable iff (!async_rst_n)
    !(clk_en && mul_call && (credits == CNT_W'(0))));

  // A multiplier result must never land in a full FIFO that is not draining.
  a_no_fifo_overflow: assert property (@(posedge clk) disable iff (!async_rst_n)
    !(fifo_push && fifo_full && !fifo_pop));

  // Credits plus buffered results can never exceed the FIFO size.
  a_credit_balance: assert property (@(posedge clk) disable iff (!async_rst_n)
    (({1'b0, credits} + {1'b0, fifo_count}) <= (CNT_W + 1)'(DEPTH)));

endmodule

// File: rtl/wb_fifo_m1.sv
// Synchronous FIFO buffering multiplier results until the write port is free.
module wb_fifo_m1
  import m1_core_pkg::*;
#(
  parameter int  DEPTH = 4,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             async_rst_n,
  input  logic             clk_en,
  input  logic             push,
  input  logic             pop,
  input  wb_entry_t        wr_entry,
  output wb_entry_t        head,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  wb_entry_t        mem_q [DEPTH];
  logic             do_push_s;
  logic             do_pop_s;

  assign full  = (count_q == CNT_W'(DEPTH));
  assign empty = (count_q == CNT_W'(0));
  assign count = count_q;
  assign head  = mem_q[rd_ptr_q];

  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign do_push_s = clk_en && push && (!full || pop);
  assign do_pop_s  = clk_en && pop && !empty;

  // Next-state pointers and occupancy.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push_s) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (do_pop_s) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({do_push_s, do_pop_s})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and occupancy registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wr_ptr_q <= PTR_W'(0);
      rd_ptr_q <= PTR_W'(0);
      count_q  <= CNT_W'(0);
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Entry storage; cleared on reset so discarded results never resurface.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else if (do_push_s) begin
      mem_q[wr_ptr_q] <= wr_entry;
    end
  end

endmodule

// File: rtl/wb_arbiter_m1.sv
// Writeback arbiter: merges ALU and M1 multiplier results onto one register-file write port.
module wb_arbiter_m1
  import m1_core_pkg::*;
#(
  parameter int  DEPTH = M1_FIFO_DEPTH,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              clk_en,
  input  logic              mul_call,
  output logic              mul_credit_ok,
  input  logic              mul_valid,
  input  logic [ADDR_W-1:0] mul_dest,
  input  logic [DATA_W-1:0] mul_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_dest,
  input  logic [DATA_W-1:0] alu_data,
  output logic              wb_en,
  output logic [ADDR_W-1:0] wb_addr,
  output logic [DATA_W-1:0] wb_data,
  output logic              idle
);

  wb_src_e           sel_s;
  wb_entry_t         mul_entry_s;
  wb_entry_t         fifo_head_s;
  logic [CNT_W-1:0]  fifo_count_s;
  logic              fifo_full_s;
  logic              fifo_empty_s;
  logic              fifo_push_s;
  logic              fifo_pop_s;
  logic              mul_ret_s;

  logic [CNT_W-1:0]  credits_q, credits_d;
  logic              wb_en_q, wb_en_d;
  logic [ADDR_W-1:0] wb_addr_q, wb_addr_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;

  assign mul_entry_s = '{dest: mul_dest, data: mul_data};

  // A full FIFO stalls the ALU so the oldest multiplier result can drain.
  assign alu_ready = !fifo_full_s;

  // Fixed priority: ALU, then buffered multiplier results, then a bypassing multiplier result.
  always_comb begin
    sel_s = WB_NONE;
    if (!clk_en) begin
      sel_s = WB_NONE;
    end else if (alu_valid && alu_ready) begin
      sel_s = WB_ALU;
    end else if (!fifo_empty_s) begin
      sel_s = WB_MUL_FIFO;
    end else if (mul_valid) begin
      sel_s = WB_MUL_BYPASS;
    end else begin
      sel_s = WB_NONE;
    end
  end

  // A multiplier result that did not bypass is buffered; buffered results keep arrival order.
  assign fifo_push_s = clk_en && mul_valid && (sel_s != WB_MUL_BYPASS);
  assign fifo_pop_s  = (sel_s == WB_MUL_FIFO);
  assign mul_ret_s   = (sel_s == WB_MUL_FIFO) || (sel_s == WB_MUL_BYPASS);

  wb_fifo_m1 #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .push        (fifo_push_s),
    .pop         (fifo_pop_s),
    .wr_entry    (mul_entry_s),
    .head        (fifo_head_s),
    .count       (fifo_count_s),
    .full        (fifo_full_s),
    .empty       (fifo_empty_s)
  );

  // Next write-port contents; address/data keep their last value when nothing is written.
  always_comb begin
    wb_en_d   = wb_en_q;
    wb_addr_d = wb_addr_q;
    wb_data_d = wb_data_q;
    case (sel_s)
      WB_ALU: begin
        wb_en_d   = 1'b1;
        wb_addr_d = alu_dest;
        wb_data_d = alu_data;
      end
      WB_MUL_FIFO: begin
        wb_en_d   = 1'b1;
        wb_addr_d = fifo_head_s.dest;
        wb_data_d = fifo_head_s.data;
      end
      WB_MUL_BYPASS: begin
        wb_en_d   = 1'b1;
        wb_addr_d = mul_dest;
        wb_data_d = mul_data;
      end
      WB_NONE: begin
        if (clk_en) begin
          wb_en_d = 1'b0;
        end else begin
          wb_en_d = wb_en_q;
        end
      end
      default: begin
        wb_en_d = 1'b0;
      end
    endcase
  end

  // Credit counter: a call reserves a FIFO slot, a written multiplier result returns it.
  always_comb begin
    credits_d = credits_q;
    if (!clk_en) begin
      credits_d = credits_q;
    end else if (mul_call && !mul_ret_s) begin
      if (credits_q != CNT_W'(0)) begin
        credits_d = credits_q - CNT_W'(1);
      end else begin
        credits_d = credits_q;
      end
    end else if (!mul_call && mul_ret_s) begin
      if (credits_q != CNT_W'(DEPTH)) begin
        credits_d = credits_q + CNT_W'(1);
      end else begin
        credits_d = credits_q;
      end
    end else begin
      credits_d = credits_q;
    end
  end

  // Write-port and credit registers.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      wb_en_q   <= 1'b0;
      wb_addr_q <= ADDR_W'(0);
      wb_data_q <= DATA_W'(0);
      credits_q <= CNT_W'(DEPTH);
    end else begin
      wb_en_q   <= wb_en_d;
      wb_addr_q <= wb_addr_d;
      wb_data_q <= wb_data_d;
      credits_q <= credits_d;
    end
  end

  assign wb_en         = wb_en_q;
  assign wb_addr       = wb_addr_q;
  assign wb_data       = wb_data_q;
  assign mul_credit_ok = (credits_q != CNT_W'(0));
  assign idle          = (credits_q == CNT_W'(DEPTH)) && fifo_empty_s && !wb_en_q;

  wb_arbiter_m1_chk #(
    .DEPTH (DEPTH),
    .CNT_W (CNT_W)
  ) u_chk (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .clk_en      (clk_en),
    .mul_call    (mul_call),
    .credits     (credits_q),
    .fifo_count  (fifo_count_s),
    .fifo_push   (fifo_push_s),
    .fifo_pop    (fifo_pop_s),
    .fifo_full   (fifo_full_s)
  );

endmodule

// File: tb/tb_wb_arbiter_m1.sv
// Self-checking bench for wb_arbiter_m1: queue-based reference model plus directed and random traffic.
module tb_wb_arbiter_m1;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        async_rst_n;
  logic        clk_en;
  logic        mul_call;
  logic        mul_credit_ok;
  logic        mul_valid;
  logic [3:0]  mul_dest;
  logic [15:0] mul_data;
  logic        alu_valid;
  logic        alu_ready;
  logic [3:0]  alu_dest;
  logic [15:0] alu_data;
  logic        wb_en;
  logic [3:0]  wb_addr;
  logic [15:0] wb_data;
  logic        idle;

  int n_checks = 0;
  int n_fail   = 0;
  bit cmp_on   = 1'b0;

  always #5 clk = ~clk;

  wb_arbiter_m1 #(.DEPTH(DEPTH)) dut (
    .clk           (clk),
    .async_rst_n   (async_rst_n),
    .clk_en        (clk_en),
    .mul_call      (mul_call),
    .mul_credit_ok (mul_credit_ok),
    .mul_valid     (mul_valid),
    .mul_dest      (mul_dest),
    .mul_data      (mul_data),
    .alu_valid     (alu_valid),
    .alu_ready     (alu_ready),
    .alu_dest      (alu_dest),
    .alu_data      (alu_data),
    .wb_en         (wb_en),
    .wb_addr       (wb_addr),
    .wb_data       (wb_data),
    .idle          (idle)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [19:0] mq[$];        // buffered multiplier results {dest,data}, oldest first
  int          m_credits;
  logic        m_wb_en;
  logic [3:0]  m_wb_addr;
  logic [15:0] m_wb_data;
  logic        m_alu_acc;    // ALU offer taken at the last edge

  always @(posedge clk or negedge async_rst_n) begin : model_p
    bit ret;
    bit byp;
    ret = 1'b0;
    byp = 1'b0;
    if (!async_rst_n) begin
      mq.delete();
      m_credits = DEPTH;
      m_wb_en   = 1'b0;
      m_wb_addr = 4'd0;
      m_wb_data = 16'd0;
      m_alu_acc = 1'b0;
    end else if (clk_en) begin
      m_alu_acc = alu_valid && (mq.size() != DEPTH);
      if (m_alu_acc) begin
        m_wb_en = 1'b1; m_wb_addr = alu_dest; m_wb_data = alu_data;
      end else if (mq.size() != 0) begin
        {m_wb_addr, m_wb_data} = mq.pop_front();
        m_wb_en = 1'b1; ret = 1'b1;
      end else if (mul_valid) begin
        m_wb_en = 1'b1; m_wb_addr = mul_dest; m_wb_data = mul_data;
        ret = 1'b1; byp = 1'b1;
      end else begin
        m_wb_en = 1'b0;
      end
      if (mul_valid && !byp) begin
        chk("fifo_room", (mq.size() < DEPTH), 1'b1);
        mq.push_back({mul_dest, mul_data});
      end
      m_credits = m_credits - (mul_call ? 1 : 0) + (ret ? 1 : 0);
      if (m_credits < 0) m_credits = 0;
    end else begin
      m_alu_acc = 1'b0;
    end
  end

  // Compare every cycle, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on && async_rst_n) begin
      chk("wb_en", wb_en, m_wb_en);
      if (m_wb_en) begin
        chk("wb_addr", wb_addr, m_wb_addr);
        chk("wb_data", wb_data, m_wb_data);
      end
      chk("alu_ready", alu_ready, (mq.size() != DEPTH));
      chk("mul_credit_ok", mul_credit_ok, (m_credits != 0));
      chk("idle", idle, (m_credits == DEPTH) && (mq.size() == 0) && !m_wb_en);
    end
  end

  // ---------------- stimulus: 2-cycle multiplier + ALU source ----------------
  logic        p1_v = 1'b0, p2_v = 1'b0;
  logic [19:0] p1_e = 20'd0, p2_e = 20'd0;
  logic        last_call = 1'b0;
  logic [19:0] last_call_e = 20'd0;
  logic        last_en = 1'b1;

  // Advance one cycle and drive the inputs for it. Calls are only made with a credit;
  // an ALU result that was not taken is held unchanged.
  task automatic step(input logic call, input logic [19:0] call_e,
                      input logic av, input logic [19:0] ae, input logic en);
    @(posedge clk); #1;
    if (last_en) begin
      p2_v = p1_v; p2_e = p1_e;
      p1_v = last_call; p1_e = last_call_e;
    end
    mul_valid = p2_v;
    {mul_dest, mul_data} = p2_e;
    if (!(alu_valid && !m_alu_acc)) begin
      alu_valid = av;
      {alu_dest, alu_data} = ae;
    end
    mul_call    = call && (m_credits != 0);
    clk_en      = en;
    last_call   = mul_call;
    last_call_e = call_e;
    last_en     = en;
  endtask

  task automatic idle_steps(input int n);
    for (int k = 0; k < n; k++) step(1'b0, 20'd0, 1'b0, 20'd0, 1'b1);
  endtask

  task automatic clear_inputs();
    mul_call = 1'b0; mul_valid = 1'b0; mul_dest = 4'd0; mul_data = 16'd0;
    alu_valid = 1'b0; alu_dest = 4'd0; alu_data = 16'd0; clk_en = 1'b1;
    p1_v = 1'b0; p2_v = 1'b0; p1_e = 20'd0; p2_e = 20'd0;
    last_call = 1'b0; last_en = 1'b1;
  endtask

  // Reset asserted in the middle of a cycle; the multiplier is cleared with it.
  task automatic pulse_reset(input string tag);
    #2;
    async_rst_n = 1'b0;
    clear_inputs();
    #1;
    chk({tag, "_rst_wb_en"}, wb_en, 1'b0);
    chk({tag, "_rst_idle"}, idle, 1'b1);
    chk({tag, "_rst_credit_ok"}, mul_credit_ok, 1'b1);
    chk({tag, "_rst_alu_ready"}, alu_ready, 1'b1);
    #3;
    async_rst_n = 1'b1;
  endtask

  initial begin
    async_rst_n = 1'b0;
    clear_inputs();
    repeat (2) @(posedge clk);
    #3 async_rst_n = 1'b1;
    @(negedge clk);
    chk("reset_wb_en", wb_en, 1'b0);
    chk("reset_wb_addr", wb_addr, 4'd0);
    chk("reset_wb_data", wb_data, 16'd0);
    chk("reset_credit_ok", mul_credit_ok, 1'b1);
    chk("reset_alu_ready", alu_ready, 1'b1);
    chk("reset_idle", idle, 1'b1);
    cmp_on = 1'b1;

    // 1: lone multiply bypasses straight to the write port
    step(1'b1, {4'd3, 16'h1234}, 1'b0, 20'd0, 1'b1);
    idle_steps(3);
    @(negedge clk);
    chk("t1_wb_en", wb_en, 1'b1);
    chk("t1_wb_addr", wb_addr, 4'd3);
    chk("t1_wb_data", wb_data, 16'h1234);
    chk("t1_busy", idle, 1'b0);
    idle_steps(1);
    @(negedge clk);
    chk("t1_idle", idle, 1'b1);
    chk("t1_wb_off", wb_en, 1'b0);

    // 2: ALU and multiplier collide; ALU first, multiplier next from the FIFO
    step(1'b1, {4'd2, 16'hBBBB}, 1'b0, 20'd0, 1'b1);
    idle_steps(1);
    step(1'b0, 20'd0, 1'b1, {4'd1, 16'hAAAA}, 1'b1);
    idle_steps(1);
    @(negedge clk);
    chk("t2_alu_addr", wb_addr, 4'd1);
    chk("t2_alu_data", wb_data, 16'hAAAA);
    idle_steps(1);
    @(negedge clk);
    chk("t2_mul_addr", wb_addr, 4'd2);
    chk("t2_mul_data", wb_data, 16'hBBBB);
    idle_steps(2);

    // 3: credit exhaustion with the ALU busy
    for (int i = 0; i < 14; i++) begin
      step(i < 4, {4'(8 + i), 16'hC000 + 16'(i)}, i < 9, {4'(i), 16'hA000 + 16'(i)}, 1'b1);
      @(negedge clk);
      if (i == 4)  chk("t3_credit_low", mul_credit_ok, 1'b0);
      if (i == 6)  chk("t3_full_stall", alu_ready, 1'b0);
      if (i == 7) begin
        chk("t3_ready_back", alu_ready, 1'b1);
        chk("t3_head_data", wb_data, 16'hC000);
        chk("t3_credit_back", mul_credit_ok, 1'b1);
      end
      if (i == 8)  chk("t3_alu_held", wb_data, 16'hA006);
      if (i == 10) chk("t3_order", wb_data, 16'hC001);
      if (i == 12) begin
        chk("t3_last_data", wb_data, 16'hC003);
        chk("t3_last_addr", wb_addr, 4'd11);
      end
      if (i == 13) chk("t3_idle", idle, 1'b1);
    end

    // 4: stall for 3 cycles with 2 results buffered
    for (int i = 0; i < 12; i++) begin
      step(i < 2, {4'(5 + i), 16'hD000 + 16'(i)}, i < 5, {4'(i), 16'hB000 + 16'(i)},
           !(i >= 5 && i <= 7));
      @(negedge clk);
      if (i >= 5 && i <= 7) begin
        chk("t4_frozen_en", wb_en, 1'b1);
        chk("t4_frozen_data", wb_data, 16'hB004);
        chk("t4_frozen_credit", mul_credit_ok, 1'b1);
      end
      if (i == 9)  chk("t4_resume0", wb_data, 16'hD000);
      if (i == 10) chk("t4_resume1", wb_data, 16'hD001);
      if (i == 11) chk("t4_drained", wb_en, 1'b0);
    end

    // 5: reset mid-cycle with 3 results buffered
    for (int i = 0; i < 7; i++) begin
      step(i < 3, {4'(i), 16'hE000 + 16'(i)}, i < 6, {4'(i), 16'h5000 + 16'(i)}, 1'b1);
    end
    #1 chk("t5_pre_wb_en", wb_en, 1'b1);
    pulse_reset("t5");
    for (int i = 0; i < 5; i++) begin
      idle_steps(1);
      @(negedge clk);
      chk("t5_no_write", wb_en, 1'b0);
    end

    // 6: call and pop together with one credit left
    for (int i = 0; i < 7; i++) begin
      step(i < 3 || i == 5, {4'(i), 16'h6000 + 16'(i)}, i < 5, {4'(i), 16'h7000 + 16'(i)}, 1'b1);
      @(negedge clk);
      if (i == 5 || i == 6) chk("t6_credit_ok", mul_credit_ok, 1'b1);
    end
    idle_steps(10);
    @(negedge clk);
    chk("t6_idle", idle, 1'b1);

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      step($urandom_range(0, 2) != 0, {4'($urandom_range(0, 15)), 16'($urandom)},
           $urandom_range(0, 1) == 1, {4'($urandom_range(0, 15)), 16'($urandom)},
           $urandom_range(0, 7) != 0);
      if (i == 1000 || i == 2000) pulse_reset("rnd");
    end
    idle_steps(30);
    @(negedge clk);
    chk("final_idle", idle, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
